ballot_collector: RTL and testbench
===================================

BALLOT_COLLECTOR -- requirements
Module: ballot_collector

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning the maximum number of cycles spent in COLLECT before forced close.
REQ-002 The block SHALL have clock clk (input, 1), and all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have reset rst_n (input, 1); one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have input start (1): a pulse that opens a new election.
REQ-005 The block SHALL have the following ballot inputs: ballot_valid (1, source has a ballot), ballot_id (3, voter index 0..4) and ballot_data (3, one-hot choice 001/010/100).
REQ-006 The block SHALL have output ballot_ready (1): the block accepts a ballot this cycle.
REQ-007 The block SHALL have outputs vote_1..vote_5 (3 each): the stored ballot per voter, which feed the downstream voter stage.
REQ-008 The block SHALL have output votes_valid (1): vote_1..vote_5 are complete and stable.
REQ-009 The block SHALL have input votes_ack (1): the downstream stage has consumed the votes.
REQ-010 The block SHALL have the following status outputs: filled_mask (5, slot i holds a ballot), timed_out (1, set when the last close was by timeout), reject (1, one-cycle pulse) and reject_code (2, reason for the reject).

Function
REQ-011 The block SHALL implement FSM states IDLE, COLLECT and DONE.
REQ-012 IDLE: on start=1, the block SHALL clear filled_mask, vote_1..5, timed_out and the timeout counter, and enter COLLECT on the next cycle.
REQ-013 ballot_ready SHALL be 1 only in COLLECT; a handshake occurs when ballot_valid && ballot_ready.
REQ-014 On a handshake, the ballot SHALL be checked and either stored or rejected; it SHALL be consumed in both cases.
REQ-015 A ballot SHALL be stored only if ballot_id<=4, ballot_data is exactly one-hot, and filled_mask[ballot_id]==0.
REQ-016 A stored ballot SHALL write vote_(ballot_id+1) and set filled_mask[ballot_id] on the next edge, with 1-cycle latency.
REQ-017 A rejected ballot SHALL pulse reject for one cycle, the cycle after the handshake, with reject_code as follows:
- 01: bad id
- 10: not one-hot (including 000)
- 11: duplicate voter
- Precedence when several apply: 01 > 10 > 11.
- A rejected ballot SHALL leave stored state unchanged.
REQ-018 When filled_mask becomes 11111, the block SHALL enter DONE in the same edge that stores the fifth ballot.
REQ-019 The COLLECT timeout counter SHALL increment every cycle in COLLECT; when it reaches TIMEOUT_CYC-1 without completion, the block SHALL enter DONE with timed_out=1.
- Unfilled slots SHALL remain 000, counting as abstentions.
REQ-020 If the fifth valid ballot and the timeout occur in the same cycle, the ballot SHALL be stored and timed_out SHALL stay 0.
REQ-021 DONE: votes_valid SHALL be 1, ballot_ready SHALL be 0, and vote_1..5, filled_mask and timed_out SHALL be held stable.
REQ-022 DONE: votes_ack=1 SHALL return the block to IDLE; votes_valid SHALL drop the next cycle, and vote_1..5 SHALL hold until the next start.
REQ-023 start asserted in COLLECT SHALL restart the election (clear all slots and the counter, remain in COLLECT), and any same-cycle ballot SHALL be discarded without reject.
REQ-024 start SHALL be ignored in DONE, and votes_ack SHALL be ignored outside DONE.
REQ-025 The timeout counter SHALL be sized to clog2(TIMEOUT_CYC) bits and SHALL saturate, never wrap.

Reset
REQ-026 When rst_n=0, the state SHALL be IDLE, and all outputs, filled_mask, vote_1..5, counters, reject, reject_code and timed_out SHALL be 0, immediately and regardless of clk.
REQ-027 A reset in any state, including mid-COLLECT, SHALL discard all partially collected ballots.
REQ-028 After rst_n deasserts, the block SHALL require start before accepting any ballot.

Structure
REQ-029 The shared package voter_pkg SHALL hold:
- candidate codes CAND_A=001, CAND_B=010 and CAND_C=100
- NUM_VOTERS=5
- the FSM state type
- the reject_code constants
REQ-030 The one-hot/id validity check SHALL be a sub-module ballot_check: combinational, with inputs id and data, and outputs ok and code.

Verification
REQ-031 Reset, then start, then ids 0..4 each with 001 back-to-back -> votes_valid=1 on the cycle after the fifth handshake, vote_1..5=001, filled_mask=11111, timed_out=0.
REQ-032 In COLLECT, id=2 data=011, then id=5 data=010, then id=1 data=010 twice -> rejects with codes 10, 01 and 11 on the respective cycles, and filled_mask=00010.
REQ-033 TIMEOUT_CYC=20, ids 0 and 3 with 100 -> DONE after 20 COLLECT cycles, timed_out=1, vote_1=vote_4=100, other slots 000.
REQ-034 Fifth ballot on the exact timeout cycle -> stored, timed_out=0; then votes_ack -> IDLE, votes_valid=0 next cycle.
REQ-035 rst_n pulsed low mid-COLLECT with 3 slots filled -> all outputs 0 immediately; a ballot offered afterwards without start -> ballot_ready=0.
REQ-036 start with 3 slots filled, with a valid ballot in the same cycle -> filled_mask=00000, no reject, and collection resumes.

Source files
------------

// File: rtl/voter_pkg.sv
// Shared definitions for the ballot collection path: candidate codes, voter count,
// collector FSM state type and reject reason codes.
package voter_pkg;

    localparam logic [2:0] CAND_A = 3'b001;
    localparam logic [2:0] CAND_B = 3'b010;
    localparam logic [2:0] CAND_C = 3'b100;

    localparam int NUM_VOTERS = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [1:0] REJ_NONE       = 2'b00;
    localparam logic [1:0] REJ_BAD_ID     = 2'b01;
    localparam logic [1:0] REJ_NOT_ONEHOT = 2'b10;
    localparam logic [1:0] REJ_DUPLICATE  = 2'b11;

    function automatic logic is_onehot3(input logic [2:0] d);
        return (d == CAND_A) || (d == CAND_B) || (d == CAND_C);
    endfunction

endpackage

// File: rtl/ballot_check.sv
// Stateless ballot screening: voter index range and one-hot choice.
// Bad id outranks a bad choice; duplicate detection needs slot state and lives in the top.
module ballot_check
    import voter_pkg::*;
(
    input  logic [2:0] id,
    input  logic [2:0] data,
    output logic       ok,
    output logic [1:0] code
);

    always_comb begin
        code = REJ_NONE;
        if (id > 3'(NUM_VOTERS - 1)) begin
            code = REJ_BAD_ID;
        end else if (!is_onehot3(data)) begin
            code = REJ_NOT_ONEHOT;
        end
        ok = (code == REJ_NONE);
    end

endmodule

// File: rtl/ballot_collector.sv
// Collects one one-hot ballot per voter into five slots, closing the election when all
// slots are filled or the collection window expires, then hands the votes downstream.
//
// Handshakes: a ballot is taken on any rising edge where ballot_valid && ballot_ready;
// ballot_ready depends only on FSM state, never on ballot_valid. The vote set is
// offered while votes_valid is high and is released on the edge where votes_ack is high.
module ballot_collector
    import voter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ballot_valid,
    input  logic [2:0]  ballot_id,
    input  logic [2:0]  ballot_data,
    output logic        ballot_ready,
    output logic [2:0]  vote_1,
    output logic [2:0]  vote_2,
    output logic [2:0]  vote_3,
    output logic [2:0]  vote_4,
    output logic [2:0]  vote_5,
    output logic        votes_valid,
    input  logic        votes_ack,
    output logic [4:0]  filled_mask,
    output logic        timed_out,
    output logic        reject,
    output logic [1:0]  reject_code,
    output state_t      state
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]      cnt;
    logic [2:0]            votes [NUM_VOTERS];

    logic                  handshake;
    logic                  chk_ok;
    logic [1:0]            chk_code;
    logic [NUM_VOTERS-1:0] slot_sel;
    logic                  dup;
    logic                  store_en;
    logic [1:0]            rej_code;
    logic [NUM_VOTERS-1:0] new_mask;

    ballot_check u_check (
        .id   (ballot_id),
        .data (ballot_data),
        .ok   (chk_ok),
        .code (chk_code)
    );

    assign ballot_ready = (state == ST_COLLECT);
    assign handshake    = ballot_valid && ballot_ready;

    // Out-of-range ids shift past the mask and select no slot.
    always_comb begin
        slot_sel = NUM_VOTERS'(1) << ballot_id;
        dup      = |(filled_mask & slot_sel);
        store_en = handshake && !start && chk_ok && !dup;
        rej_code = chk_ok ? REJ_DUPLICATE : chk_code;
        new_mask = filled_mask | slot_sel;
    end

    assign vote_1 = votes[0];
    assign vote_2 = votes[1];
    assign vote_3 = votes[2];
    assign vote_4 = votes[3];
    assign vote_5 = votes[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            filled_mask <= '0;
            timed_out   <= 1'b0;
            votes_valid <= 1'b0;
            reject      <= 1'b0;
            reject_code <= REJ_NONE;
            for (int i = 0; i < NUM_VOTERS; i++) votes[i] <= '0;
        end else begin
            reject      <= 1'b0;
            reject_code <= REJ_NONE;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        filled_mask <= '0;
                        timed_out   <= 1'b0;
                        for (int i = 0; i < NUM_VOTERS; i++) votes[i] <= '0;
                        state       <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (start) begin
                        // Restart: a ballot offered in the same cycle is dropped silently.
                        cnt         <= '0;
                        filled_mask <= '0;
                        for (int i = 0; i < NUM_VOTERS; i++) votes[i] <= '0;
                    end else begin
                        if (handshake && !store_en) begin
                            reject      <= 1'b1;
                            reject_code <= rej_code;
                        end
                        if (store_en) begin
                            filled_mask <= new_mask;
                            for (int i = 0; i < NUM_VOTERS; i++)
                                if (ballot_id == 3'(i)) votes[i] <= ballot_data;
                        end
                        // A completing ballot wins over a coincident timeout.
                        if (store_en && new_mask == '1) begin
                            state       <= ST_DONE;
                            votes_valid <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            state       <= ST_DONE;
                            timed_out   <= 1'b1;
                            votes_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (votes_ack) begin
                        state       <= ST_IDLE;
                        votes_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector: an election-level reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_ballot_collector;
    import voter_pkg::*;

    localparam int TO = 20;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ballot_valid;
    logic [2:0]  ballot_id;
    logic [2:0]  ballot_data;
    logic        ballot_ready;
    logic [2:0]  vote_1, vote_2, vote_3, vote_4, vote_5;
    logic        votes_valid;
    logic        votes_ack;
    logic [4:0]  filled_mask;
    logic        timed_out;
    logic        reject;
    logic [1:0]  reject_code;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    ballot_collector #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ballot_valid (ballot_valid),
        .ballot_id    (ballot_id),
        .ballot_data  (ballot_data),
        .ballot_ready (ballot_ready),
        .vote_1       (vote_1),
        .vote_2       (vote_2),
        .vote_3       (vote_3),
        .vote_4       (vote_4),
        .vote_5       (vote_5),
        .votes_valid  (votes_valid),
        .votes_ack    (votes_ack),
        .filled_mask  (filled_mask),
        .timed_out    (timed_out),
        .reject       (reject),
        .reject_code  (reject_code),
        .state        (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: election phase + ballot box ----------------
    int         m_phase;          // 0 idle, 1 collecting, 2 closed
    logic [2:0] m_vote [5];
    int         m_age;            // collecting cycles already elapsed
    bit         m_timed;
    bit         m_rej;
    logic [1:0] m_code;

    function automatic int reason(input logic [2:0] id, input logic [2:0] d);
        if (id >= 3'd5) return 1;
        if ($countones(d) != 1) return 2;
        if (m_vote[id] != 3'b000) return 3;
        return 0;
    endfunction

    function automatic bit would_fill(input logic [2:0] id);
        int n = 0;
        for (int j = 0; j < 5; j++) if (m_vote[j] != 3'b000 || j == int'(id)) n++;
        return n == 5;
    endfunction

    function automatic logic [4:0] m_mask();
        logic [4:0] r = '0;
        for (int j = 0; j < 5; j++) r[j] = (m_vote[j] != 3'b000);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_age   <= 0;
            m_timed <= 0;
            m_rej   <= 0;
            m_code  <= 2'b00;
            for (int j = 0; j < 5; j++) m_vote[j] <= 3'b000;
        end else begin
            m_rej  <= 0;
            m_code <= 2'b00;
            if (m_phase == 0) begin
                if (start) begin
                    for (int j = 0; j < 5; j++) m_vote[j] <= 3'b000;
                    m_age   <= 0;
                    m_timed <= 0;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (start) begin
                    for (int j = 0; j < 5; j++) m_vote[j] <= 3'b000;
                    m_age <= 0;
                end else begin
                    if (ballot_valid && reason(ballot_id, ballot_data) != 0) begin
                        m_rej  <= 1;
                        m_code <= 2'(reason(ballot_id, ballot_data));
                    end
                    if (ballot_valid && reason(ballot_id, ballot_data) == 0)
                        m_vote[ballot_id] <= ballot_data;
                    if (ballot_valid && reason(ballot_id, ballot_data) == 0 && would_fill(ballot_id))
                        m_phase <= 2;
                    else if (m_age == TO - 1) begin
                        m_phase <= 2;
                        m_timed <= 1;
                    end else
                        m_age <= m_age + 1;
                end
            end else begin
                if (votes_ack) m_phase <= 0;
            end
        end
    end

    // scoreboard compare, every cycle, away from the active edge
    always @(negedge clk) begin
        chk("m_ready",  32'(ballot_ready), 32'(m_phase == 1));
        chk("m_valid",  32'(votes_valid),  32'(m_phase == 2));
        chk("m_mask",   32'(filled_mask),  32'(m_mask()));
        chk("m_timed",  32'(timed_out),    32'(m_timed));
        chk("m_reject", 32'(reject),       32'(m_rej));
        chk("m_code",   32'(reject_code),  32'(m_code));
        chk("m_vote1",  32'(vote_1),       32'(m_vote[0]));
        chk("m_vote2",  32'(vote_2),       32'(m_vote[1]));
        chk("m_vote3",  32'(vote_3),       32'(m_vote[2]));
        chk("m_vote4",  32'(vote_4),       32'(m_vote[3]));
        chk("m_vote5",  32'(vote_5),       32'(m_vote[4]));
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit s, input bit v, input int id, input logic [2:0] d, input bit ack);
        @(negedge clk);
        start        = s;
        ballot_valid = v;
        ballot_id    = 3'(id);
        ballot_data  = d;
        votes_ack    = ack;
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'b000, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(ballot_ready), 0);
        chk({tag, "_valid"}, 32'(votes_valid), 0);
        chk({tag, "_mask"},  32'(filled_mask), 0);
        chk({tag, "_timed"}, 32'(timed_out), 0);
        chk({tag, "_rej"},   32'(reject), 0);
        chk({tag, "_code"},  32'(reject_code), 0);
        chk({tag, "_votes"}, 32'({vote_1, vote_2, vote_3, vote_4, vote_5}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        rst_n = 1'b0;
        start = 0; ballot_valid = 0; ballot_id = 0; ballot_data = 0; votes_ack = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // full election, back-to-back ballots
        drive(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, i, 3'b001, 0);
        drive(0, 0, 0, 3'b000, 1);
        chk("full_valid", 32'(votes_valid), 1);
        chk("full_mask",  32'(filled_mask), 32'h1f);
        chk("full_timed", 32'(timed_out), 0);
        chk("full_votes", 32'({vote_1, vote_2, vote_3, vote_4, vote_5}), 32'o11111);
        idle();
        chk("ack_valid_drop", 32'(votes_valid), 0);
        chk("ack_votes_hold", 32'({vote_1, vote_2, vote_3, vote_4, vote_5}), 32'o11111);

        // reject codes and precedence
        drive(1, 0, 0, 3'b000, 0);
        drive(0, 1, 2, 3'b011, 0);
        drive(0, 1, 5, 3'b010, 0);
        chk("rej_onehot", 32'({reject, reject_code}), 32'b110);
        drive(0, 1, 1, 3'b010, 0);
        chk("rej_badid", 32'({reject, reject_code}), 32'b101);
        drive(0, 1, 1, 3'b010, 0);
        chk("store_norej", 32'(reject), 0);
        drive(0, 1, 7, 3'b000, 0);
        chk("rej_dup", 32'({reject, reject_code}), 32'b111);
        drive(0, 0, 0, 3'b000, 0);
        chk("rej_badid_prec", 32'({reject, reject_code}), 32'b101);
        chk("rej_mask", 32'(filled_mask), 32'b00010);

        // restart mid-collection with a same-cycle ballot
        drive(0, 1, 0, 3'b001, 0);
        drive(0, 1, 4, 3'b010, 0);
        idle();
        chk("pre_restart_mask", 32'(filled_mask), 32'b10011);
        drive(1, 1, 2, 3'b001, 0);
        idle();
        chk("restart_mask", 32'(filled_mask), 0);
        chk("restart_norej", 32'(reject), 0);
        chk("restart_ready", 32'(ballot_ready), 1);
        drive(0, 1, 2, 3'b001, 0);
        idle();
        chk("resume_mask", 32'(filled_mask), 32'b00100);
        chk("resume_vote3", 32'(vote_3), 32'b001);

        // timeout with two ballots, measured in collecting cycles
        drive(1, 0, 0, 3'b000, 0);
        n = 0;
        drive(0, 1, 0, 3'b100, 0);
        n += int'(ballot_ready);
        drive(0, 1, 3, 3'b100, 0);
        n += int'(ballot_ready);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            idle();
            if (votes_valid) seen = 1;
            else if (ballot_ready) n++;
        end
        chk("to_closed", 32'(seen), 1);
        chk("to_cycles", 32'(n), 32'(TO));
        chk("to_timed",  32'(timed_out), 1);
        chk("to_mask",   32'(filled_mask), 32'b01001);
        chk("to_votes",  32'({vote_1, vote_2, vote_3, vote_4, vote_5}), 32'o40040);
        drive(1, 1, 1, 3'b001, 0);
        idle();
        chk("done_ign_start", 32'({votes_valid, filled_mask}), 32'b101001);
        drive(0, 0, 0, 3'b000, 1);
        idle();
        chk("to_ack", 32'(votes_valid), 0);

        // fifth ballot lands on the final collecting cycle
        drive(1, 0, 0, 3'b000, 0);
        drive(0, 1, 0, 3'b001, 0);
        drive(0, 1, 1, 3'b010, 0);
        drive(0, 1, 2, 3'b100, 0);
        drive(0, 1, 3, 3'b001, 0);
        repeat (15) idle();
        drive(0, 1, 4, 3'b010, 0);
        chk("edge_ready", 32'(ballot_ready), 1);
        idle();
        chk("edge_valid", 32'(votes_valid), 1);
        chk("edge_timed", 32'(timed_out), 0);
        chk("edge_mask",  32'(filled_mask), 32'h1f);
        chk("edge_votes", 32'({vote_1, vote_2, vote_3, vote_4, vote_5}), 32'o12412);
        drive(0, 0, 0, 3'b000, 1);
        idle();
        chk("edge_ack", 32'({votes_valid, ballot_ready}), 0);

        // asynchronous reset mid-collection
        drive(1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, i, 3'b100, 0);
        idle();
        chk("prereset_mask", 32'(filled_mask), 32'b00111);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 3'b001, 0);
        chk("nostart_ready", 32'(ballot_ready), 0);
        idle();
        chk("nostart_mask", 32'(filled_mask), 0);
        chk("nostart_rej", 32'(reject), 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
